// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and helpers for the RC4 XOR packer datapath
package rc4_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_RD,
      XOR,
      WRITE,
      DONE
   } state_t;

   // Big-endian lanes: lane 0 sits in the most significant byte of the word.
   function automatic int lane_offset(input int k, input int lanes);
      return BYTE_W * (lanes - 1 - k);
   endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up-counter with synchronous clear that stops at a rollover value
module flex_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   assign at_max = (count == rollover_val);

   // Saturates rather than wraps, so a full-range total never aliases back to zero.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_enable && !at_max) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/rc4_xor_packer.sv
// rtl/rc4_xor_packer.sv - fetches cipher words, XORs keystream bytes per lane, writes strobed plaintext words
module rc4_xor_packer
   import rc4_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int PIX_W  = 20,
   parameter int ADDR_W = PIX_W - $clog2(LANES)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start_i,
   input  logic [PIX_W-1:0]        total_bytes_i,
   input  logic                    ks_valid_i,
   input  logic [BYTE_W-1:0]       ks_byte_i,
   output logic                    ks_ready_o,
   output logic                    rd_req_o,
   output logic [ADDR_W-1:0]       rd_addr_o,
   input  logic                    rd_valid_i,
   input  logic [BYTE_W*LANES-1:0] rd_data_i,
   output logic                    wr_en_o,
   output logic [ADDR_W-1:0]       wr_addr_o,
   output logic [BYTE_W*LANES-1:0] wr_data_o,
   output logic [LANES-1:0]        wr_strobe_o,
   input  logic                    wr_ready_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [PIX_W-1:0]        byte_cnt_o
);

   localparam int LOG2   = $clog2(LANES);
   localparam int LANE_W = (LANES > 1) ? LOG2 : 1;
   localparam int WORD_W = BYTE_W * LANES;

   state_t              state;
   logic [PIX_W-1:0]    total;
   logic [PIX_W-1:0]    byte_cnt;
   logic [PIX_W-1:0]    cnt_next;
   logic [WORD_W-1:0]   cipher;
   logic [WORD_W-1:0]   data;
   logic [LANES-1:0]    strobe;
   logic [ADDR_W-1:0]   word_addr;
   logic [LANE_W-1:0]   lane;
   logic                accept_start;
   logic                consume;
   logic                at_total;
   logic                last_lane;
   logic                last_byte;

   assign accept_start = (state == IDLE) && start_i;
   assign consume      = (state == XOR) && ks_valid_i;
   assign lane         = (LANES > 1) ? byte_cnt[LANE_W-1:0] : '0;
   assign cnt_next     = byte_cnt + PIX_W'(1);
   assign last_lane    = (lane == LANE_W'(LANES - 1));
   assign last_byte    = (cnt_next == total);

   flex_counter #(
      .WIDTH (PIX_W)
   ) u_byte_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (accept_start),
      .count_enable (consume),
      .rollover_val (total),
      .count        (byte_cnt),
      .at_max       (at_total)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         total     <= '0;
         cipher    <= '0;
         data      <= '0;
         strobe    <= '0;
         word_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  total <= total_bytes_i;
                  state <= (total_bytes_i == '0) ? DONE : FETCH;
               end
            end
            FETCH: begin
               word_addr <= ADDR_W'(byte_cnt >> LOG2);
               state     <= WAIT_RD;
            end
            WAIT_RD: begin
               if (rd_valid_i) begin
                  cipher <= rd_data_i;
                  data   <= '0;
                  strobe <= '0;
                  state  <= XOR;
               end
            end
            XOR: begin
               if (ks_valid_i) begin
                  for (int k = 0; k < LANES; k++) begin
                     if (lane == LANE_W'(k)) begin
                        data[lane_offset(k, LANES) +: BYTE_W] <=
                           ks_byte_i ^ cipher[lane_offset(k, LANES) +: BYTE_W];
                        strobe[LANES-1-k] <= 1'b1;
                     end
                  end
                  if (last_lane || last_byte) begin
                     state <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (wr_ready_i) begin
                  state <= at_total ? DONE : FETCH;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Every output is a decode of registered state, so none depend on inputs combinationally.
   assign ks_ready_o  = (state == XOR);
   assign rd_req_o    = (state == FETCH);
   assign rd_addr_o   = ADDR_W'(byte_cnt >> LOG2);
   assign wr_en_o     = (state == WRITE);
   assign wr_addr_o   = word_addr;
   assign wr_data_o   = data;
   assign wr_strobe_o = strobe;
   assign busy_o      = (state != IDLE);
   assign done_o      = (state == DONE);
   assign byte_cnt_o  = byte_cnt;

endmodule

// File: tb/tb_rc4_xor_packer.sv
// tb/tb_rc4_xor_packer.sv - table, corner-case and randomized checks for rc4_xor_packer
module tb_rc4_xor_packer;

   localparam int LANES  = 4;
   localparam int PIX_W  = 20;
   localparam int ADDR_W = 18;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              start_i;
   logic [PIX_W-1:0]  total_bytes_i;
   logic              ks_valid_i;
   logic [7:0]        ks_byte_i;
   logic              ks_ready_o;
   logic              rd_req_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic              rd_valid_i;
   logic [31:0]       rd_data_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [31:0]       wr_data_o;
   logic [3:0]        wr_strobe_o;
   logic              wr_ready_i;
   logic              busy_o;
   logic              done_o;
   logic [PIX_W-1:0]  byte_cnt_o;

   always #5 clk = ~clk;

   rc4_xor_packer #(.LANES(LANES), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .n_rst(n_rst), .start_i(start_i), .total_bytes_i(total_bytes_i),
      .ks_valid_i(ks_valid_i), .ks_byte_i(ks_byte_i), .ks_ready_o(ks_ready_o),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_valid_i(rd_valid_i),
      .rd_data_i(rd_data_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .wr_strobe_o(wr_strobe_o), .wr_ready_i(wr_ready_i),
      .busy_o(busy_o), .done_o(done_o), .byte_cnt_o(byte_cnt_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] mem    [0:15];
   logic [7:0]  ks_src [0:255];

   logic [ADDR_W-1:0] got_addr[$];
   logic [31:0]       got_data[$];
   logic [3:0]        got_strb[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];
   logic [3:0]        exp_strb[$];

   int done_cnt, done_at, reads, ks_used, first_rd, last_busy;

   typedef struct {
      int          total;
      logic [7:0]  ks;
      int          n_wr;
      logic [31:0] d0;
      logic [3:0]  s0;
      logic [31:0] d1;
      logic [3:0]  s1;
   } vec_t;

   vec_t vecs [0:4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start_i       = 1'b0;
      total_bytes_i = '0;
      ks_valid_i    = 1'b0;
      ks_byte_i     = '0;
      rd_valid_i    = 1'b0;
      rd_data_i     = '0;
      wr_ready_i    = 1'b0;
   endtask

   // Reference: byte n is keystream n XOR lane n%4 of cipher word n/4, lane 0 in the top byte.
   task automatic build_model(input int total);
      int words;
      logic [31:0] d;
      logic [3:0]  s;
      exp_addr.delete(); exp_data.delete(); exp_strb.delete();
      words = (total + 3) / 4;
      for (int w = 0; w < words; w++) begin
         d = '0; s = '0;
         for (int k = 0; k < 4; k++) begin
            if (4 * w + k < total) begin
               d[8*(3-k) +: 8] = mem[w][8*(3-k) +: 8] ^ ks_src[4*w+k];
               s[3-k] = 1'b1;
            end
         end
         exp_addr.push_back(ADDR_W'(w));
         exp_data.push_back(d);
         exp_strb.push_back(s);
      end
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_nwrites"}, 64'(got_data.size()), 64'(exp_data.size()));
      for (int j = 0; j < exp_data.size() && j < got_data.size(); j++) begin
         check({tag, "_addr"}, 64'(got_addr[j]), 64'(exp_addr[j]));
         check({tag, "_data"}, 64'(got_data[j]), 64'(exp_data[j]));
         check({tag, "_strobe"}, 64'(got_strb[j]), 64'(exp_strb[j]));
      end
   endtask

   // Drives one frame cycle by cycle; inputs change on the falling edge, outputs are sampled there too.
   task automatic run_frame(input int total, input int gap, input int stall, input int lat,
                            input bit mid_start, input int abort_at);
      int rd_due, stall_left, ks_idx;
      logic [ADDR_W-1:0] pend_addr;
      bit in_write;
      logic [ADDR_W-1:0] snap_addr;
      logic [31:0] snap_data;
      logic [3:0]  snap_strb;
      logic [PIX_W-1:0] snap_cnt;
      got_addr.delete(); got_data.delete(); got_strb.delete();
      done_cnt = 0; done_at = -1; reads = 0; first_rd = -1; last_busy = 0;
      rd_due = -1; stall_left = 0; ks_idx = 0; in_write = 0; pend_addr = '0;
      snap_addr = '0; snap_data = '0; snap_strb = '0; snap_cnt = '0;
      @(negedge clk);
      start_i = 1'b1;
      total_bytes_i = PIX_W'(total);
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         start_i = (mid_start && i == 5);
         total_bytes_i = PIX_W'(3);
         if (abort_at > 0 && ks_ready_o && byte_cnt_o == PIX_W'(abort_at)) begin
            n_rst = 1'b0;
            idle_inputs();
            #1;
            check("abort_outputs_zero",
                  64'({ks_ready_o, rd_req_o, wr_en_o, busy_o, done_o, |rd_addr_o,
                       |wr_addr_o, |wr_data_o, |wr_strobe_o, |byte_cnt_o}), 64'd0);
            check("abort_no_write", 64'(got_data.size()), 64'd0);
            ks_used = ks_idx;
            return;
         end
         if (done_o) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (rd_req_o) begin
            reads++;
            if (first_rd < 0) first_rd = i;
            pend_addr = rd_addr_o;
            rd_due = i + lat;
         end
         rd_valid_i = (i == rd_due);
         rd_data_i  = mem[pend_addr[3:0]];
         ks_valid_i = (i % gap == 0);
         ks_byte_i  = ks_src[ks_idx % 256];
         if (ks_valid_i && ks_ready_o) ks_idx++;
         wr_ready_i = 1'b0;
         if (wr_en_o) begin
            if (!in_write) begin
               in_write = 1; stall_left = stall;
               snap_addr = wr_addr_o; snap_data = wr_data_o;
               snap_strb = wr_strobe_o; snap_cnt = byte_cnt_o;
            end else begin
               check("stall_addr", 64'(wr_addr_o), 64'(snap_addr));
               check("stall_data", 64'(wr_data_o), 64'(snap_data));
               check("stall_strobe", 64'(wr_strobe_o), 64'(snap_strb));
               check("stall_ks_ready", 64'(ks_ready_o), 64'd0);
               check("stall_byte_cnt", 64'(byte_cnt_o), 64'(snap_cnt));
            end
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               wr_ready_i = 1'b1;
               in_write = 0;
               got_addr.push_back(wr_addr_o);
               got_data.push_back(wr_data_o);
               got_strb.push_back(wr_strobe_o);
            end
         end else if (in_write) begin
            check("stall_wr_en_held", 64'(wr_en_o), 64'd1);
            in_write = 0;
         end
         if (done_at >= 0 && i >= done_at + 3) begin
            last_busy = busy_o;
            break;
         end
      end
      ks_used = ks_idx;
      idle_inputs();
      check("done_pulse_count", 64'(done_cnt), 64'd1);
   endtask

   initial begin
      logic [31:0] full_d0, full_d1;
      int total, gap, stall, lat;

      vecs[0] = '{8, 8'hFF, 2, 32'hEEDDCCBB, 4'hF, 32'hAA998877, 4'hF};
      vecs[1] = '{6, 8'h00, 2, 32'h11223344, 4'hF, 32'h55660000, 4'hC};
      vecs[2] = '{5, 8'h0F, 2, 32'h1E2D3C4B, 4'hF, 32'h5A000000, 4'h8};
      vecs[3] = '{4, 8'hA5, 1, 32'hB48796E1, 4'hF, 32'h0,        4'h0};
      vecs[4] = '{1, 8'h01, 1, 32'h10000000, 4'h8, 32'h0,        4'h0};

      n_rst = 1'b0;
      idle_inputs();
      for (int j = 0; j < 16; j++) mem[j] = '0;
      for (int j = 0; j < 256; j++) ks_src[j] = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs_zero",
            64'({ks_ready_o, rd_req_o, wr_en_o, busy_o, done_o, |rd_addr_o,
                 |wr_addr_o, |wr_data_o, |wr_strobe_o, |byte_cnt_o}), 64'd0);
      n_rst = 1'b1;
      @(negedge clk);
      check("idle_busy_after_reset", 64'(busy_o), 64'd0);

      // Table vectors: fixed cipher words, constant keystream byte, no gaps or stalls.
      mem[0] = 32'h11223344;
      mem[1] = 32'h55667788;
      for (int v = 0; v < 5; v++) begin
         for (int j = 0; j < 256; j++) ks_src[j] = vecs[v].ks;
         exp_addr.delete(); exp_data.delete(); exp_strb.delete();
         exp_addr.push_back('0); exp_data.push_back(vecs[v].d0); exp_strb.push_back(vecs[v].s0);
         if (vecs[v].n_wr == 2) begin
            exp_addr.push_back(ADDR_W'(1)); exp_data.push_back(vecs[v].d1);
            exp_strb.push_back(vecs[v].s1);
         end
         run_frame(vecs[v].total, 1, 0, 1, 0, 0);
         compare_writes("table");
         check("table_byte_cnt", 64'(byte_cnt_o), 64'(vecs[v].total));
         check("table_first_rd", 64'(first_rd), 64'd1);
         check("table_reads", 64'(reads), 64'(vecs[v].n_wr));
         check("table_done_cycle", 64'(done_at),
               64'(3 * ((vecs[v].total + 3) / 4) + vecs[v].total + 1));
      end

      // Zero-length frame.
      run_frame(0, 1, 0, 1, 0, 0);
      check("zero_reads", 64'(reads), 64'd0);
      check("zero_writes", 64'(got_data.size()), 64'd0);
      check("zero_done_soon", 64'(done_at >= 1 && done_at <= 2), 64'd1);

      // Write back-pressure on every word.
      for (int j = 0; j < 256; j++) ks_src[j] = 8'hFF;
      full_d0 = 32'hEEDDCCBB; full_d1 = 32'hAA998877;
      build_model(8);
      check("model_matches_table0", 64'({exp_data[0], exp_data[1]}), 64'({full_d0, full_d1}));
      run_frame(8, 1, 5, 1, 0, 0);
      compare_writes("stall");
      check("stall_ks_consumed", 64'(ks_used), 64'd8);

      // Gapped keystream with a stray start mid-frame.
      run_frame(8, 3, 0, 1, 1, 0);
      compare_writes("gapped");
      check("gapped_no_restart", 64'(last_busy), 64'd0);
      check("gapped_byte_cnt", 64'(byte_cnt_o), 64'd8);

      // Reset in XOR after two bytes, then a clean frame.
      run_frame(8, 1, 0, 1, 0, 2);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 256; j++) ks_src[j] = 8'hA5;
      build_model(4);
      run_frame(4, 1, 0, 1, 0, 0);
      compare_writes("post_reset");
      check("post_reset_done_cycle", 64'(done_at), 64'd8);

      // Randomized frames against the reference model.
      for (int r = 0; r < 40; r++) begin
         total = $urandom_range(60, 1);
         gap   = $urandom_range(3, 1);
         stall = $urandom_range(2, 0);
         lat   = $urandom_range(3, 1);
         for (int j = 0; j < 16; j++) mem[j] = $urandom;
         for (int j = 0; j < 256; j++) ks_src[j] = 8'($urandom);
         build_model(total);
         run_frame(total, gap, stall, lat, 0, 0);
         compare_writes("rand");
         check("rand_byte_cnt", 64'(byte_cnt_o), 64'(total));
         check("rand_ks_consumed", 64'(ks_used), 64'(total));
         check("rand_reads", 64'(reads), 64'((total + 3) / 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
